store_fwd_buffer: RTL and testbench
===================================

# store_fwd_buffer

Parametrised successor to the LSU store buffer. It keeps a speculative FIFO and a commit FIFO with configurable depth and data width, and drains committed stores to the D$ request port. It adds full-address store-to-load forwarding with byte-enable coverage checking, and tells the load unit to stall on any partial overlap. It sits between the LSU store path, the load unit and the D$ store port, and carries the per-entry `approx` tag through to memory.

## Interface
- `DEPTH_SPEC`, 4: speculative entries; power of two, ≥2.
- `DEPTH_COMMIT`, 8: commit entries; power of two, ≥2.
- `DATA_W`, 64: store data width; `BE_W = DATA_W/8`; `OFF_W = $clog2(BE_W)`.
- `ADDR_W`, 64: physical address width.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `flush_i` in 1: drop all speculative entries.
- `valid_i` in 1: push a store. Fields `paddr_i` ADDR_W, `data_i` DATA_W, `be_i` BE_W, `size_i` 2, `approx_i` 1.
- `ready_o` out 1: the speculative queue can accept a push.
- `commit_i` in 1: move the oldest speculative entry to the commit queue.
- `commit_ready_o` out 1: the commit queue has space.
- `no_st_pending_o` out 1: the commit queue is empty.
- `ld_valid_i` in 1: load probe. Fields `ld_paddr_i` ADDR_W, `ld_be_i` BE_W.
- `ld_fwd_hit_o` out 1: forwarded data is valid.
- `ld_fwd_data_o` out DATA_W: forwarded data.
- `ld_stall_o` out 1: the load must wait for the buffer to drain.
- `mem_req_o` out 1: request to the D$. Fields `mem_addr_o`, `mem_wdata_o`, `mem_be_o`, `mem_size_o`, `mem_approx_o`.
- `mem_gnt_i` in 1: D$ grant.

## Operation
- Each entry holds addr, data, be, size, approx, valid.
- Both queues are circular FIFOs with read/write pointers of width `$clog2(DEPTH)` and a count of width `$clog2(DEPTH)+1`. Pointers wrap naturally.
- `ready_o = spec_cnt_q < DEPTH_SPEC`.
- `commit_ready_o = commit_cnt_q < DEPTH_COMMIT`.
- Neither ready signal bypasses a same-cycle pop.
- Push: when `valid_i`, write the entry at `spec_wptr` and increment the pointer and count. `valid_i` while `!ready_o` is illegal and is asserted against.
- Commit: when `commit_i`, copy `spec[rptr]` to `commit[wptr]`, clear the speculative entry's valid bit, and advance both pointers. Push and commit in the same cycle leave `spec_cnt` unchanged. Commit with an empty speculative queue or a full commit queue is illegal.
- Flush: clear all speculative valid bits, set `spec_wptr = spec_rptr`, set `spec_cnt = 0`. A push in the flush cycle is dropped. `commit_i` together with `flush_i` is illegal; if it occurs, flush wins and the commit is ignored. Commit-queue contents are never flushed.
- Drain: `mem_req_o = commit[rptr].valid`. Address, data, be, size and approx come from the head entry. On `mem_gnt_i`, invalidate the head, advance the pointer and decrement the count. A grant and a commit in the same cycle leave `commit_cnt` unchanged. `rvalid` is ignored.
- Forwarding is purely combinational from `_q` state.
  - Word match: `entry.valid && entry.addr[ADDR_W-1:OFF_W] == ld_paddr_i[ADDR_W-1:OFF_W]`.
  - Search order, youngest first: the speculative queue from `spec_wptr-1` back to `spec_rptr`, then the commit queue from `commit_wptr-1` back to `commit_rptr`.
  - The first word match is selected.
  - `ld_fwd_hit_o = ld_valid_i && match && (sel.be & ld_be_i) == ld_be_i`. On a hit, `ld_fwd_data_o = sel.data`; otherwise it is 0.
  - `ld_stall_o = ld_valid_i && !ld_fwd_hit_o && X`, where X is any of:
    - a valid entry of either queue whose `addr[11:OFF_W]` equals `ld_paddr_i[11:OFF_W]`;
    - `valid_i` with `paddr_i[11:OFF_W]` equal to the load's.
  - A hit with a same-cycle matching push is not a hit. That case stalls, because the incoming store is younger.

## Timing
- Reset values:
  - all entries invalid, pointers and counts 0;
  - `ready_o = 1`, `commit_ready_o = 1`, `no_st_pending_o = 1`;
  - `mem_req_o = 0`, `ld_fwd_hit_o = 0`, `ld_stall_o = 0`, `ld_fwd_data_o = 0`.
- Reset in mid-operation discards every entry, including committed ones; the core must not commit stores it still needs.
- Push to forwardable: 1 cycle. A store pushed at edge N is visible to probes from cycle N+1.
- Commit to `mem_req_o`: 1 cycle, when the commit queue was empty.
- `mem_req_o` stays high with stable fields until `mem_gnt_i`. Back-to-back grants drain one entry per cycle.
- All probe outputs are same-cycle combinational.

## Structure
- Package (`ariane_pkg`): the `sb_entry_t` typedef (parametrised by DATA_W/ADDR_W through localparams) and the default `DEPTH_SPEC`/`DEPTH_COMMIT` constants.
- Sub-module `sb_fwd_select`: a youngest-first priority matcher over one queue. It takes the entry array, read pointer, write pointer and probe address, and returns match, index and page-offset-hit. It is instantiated twice, once per queue.

## Test plan
- Push `addr 0x1000`, `data 0x1122334455667788`, `be 0xFF`; probe `0x1000` with `be 0x0F` next cycle → `ld_fwd_hit_o = 1`, data `0x1122334455667788`, `ld_stall_o = 0`.
- Push `be 0x0F` to `0x1000`, then `be 0xF0` to `0x1000`; probe with `be 0xFF` → youngest entry is `be 0xF0`, so no hit and `ld_stall_o = 1`.
- Push 3, commit 1, flush → `spec_cnt` 0, commit count 1. Probe the flushed address → no stall. `mem_req_o` stays high until the grant, then `no_st_pending_o = 1`.
- With DEPTH_COMMIT=8 and `mem_gnt_i = 0`, fill 8 commits → `commit_ready_o = 0`. Raise the grant for 1 cycle → `commit_ready_o = 1` the next cycle, and data comes out in FIFO order.
- Wrap-around: 3×DEPTH_SPEC push/commit pairs with random grants → every store reaches `mem_*` exactly once, in order, with `approx` preserved.
- Probe `0x2008` while pushing `0x3008` in the same cycle → `ld_stall_o = 1` (page-offset match), `ld_fwd_hit_o = 0`.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared store-buffer types and default queue depths.
package ariane_pkg;

  localparam int SB_DATA_W       = 64;
  localparam int SB_ADDR_W       = 64;
  localparam int SB_BE_W         = SB_DATA_W / 8;
  localparam int SB_DEPTH_SPEC   = 4;
  localparam int SB_DEPTH_COMMIT = 8;

  typedef struct packed {
    logic                 valid;
    logic                 approx;
    logic [1:0]           size;
    logic [SB_BE_W-1:0]   be;
    logic [SB_DATA_W-1:0] data;
    logic [SB_ADDR_W-1:0] addr;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_select.sv
// Youngest-first word matcher over one circular queue, plus a page-offset alias detector.
module sb_fwd_select #(
  parameter  int DEPTH  = 4,
  parameter  int WORD_W = 61,
  parameter  int PAGE_W = 9,
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  valid,
  input  logic [WORD_W-1:0] word [DEPTH],
  input  logic [PW-1:0]     rptr,
  input  logic [PW-1:0]     wptr,
  input  logic [WORD_W-1:0] probe_word,
  output logic              match,
  output logic [PW-1:0]     index,
  output logic              page_hit
);

  localparam int UW = PW + 1;

  logic [UW-1:0] used;
  logic [PW-1:0] idx;

  // A full queue has wptr == rptr, so the head's valid bit disambiguates full from empty.
  always_comb begin
    used     = (wptr == rptr && valid[rptr]) ? UW'(DEPTH) : {1'b0, wptr - rptr};
    match    = 1'b0;
    index    = '0;
    page_hit = 1'b0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = wptr - PW'(k + 1);
      if (!match && UW'(k) < used && valid[idx] && word[idx] == probe_word) begin
        match = 1'b1;
        index = idx;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (valid[k] && word[k][PAGE_W-1:0] == probe_word[PAGE_W-1:0]) page_hit = 1'b1;
    end
  end

endmodule

// File: rtl/store_fwd_buffer.sv
// Speculative + commit store queues draining to the D$, with store-to-load forwarding.
module store_fwd_buffer
  import ariane_pkg::*;
#(
  parameter  int DEPTH_SPEC   = SB_DEPTH_SPEC,
  parameter  int DEPTH_COMMIT = SB_DEPTH_COMMIT,
  parameter  int DATA_W       = SB_DATA_W,
  parameter  int ADDR_W       = SB_ADDR_W,
  localparam int BE_W         = DATA_W / 8,
  localparam int OFF_W        = $clog2(BE_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [1:0]        size_i,
  input  logic              approx_i,
  output logic              ready_o,
  input  logic              commit_i,
  output logic              commit_ready_o,
  output logic              no_st_pending_o,
  input  logic              ld_valid_i,
  input  logic [ADDR_W-1:0] ld_paddr_i,
  input  logic [BE_W-1:0]   ld_be_i,
  output logic              ld_fwd_hit_o,
  output logic [DATA_W-1:0] ld_fwd_data_o,
  output logic              ld_stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [BE_W-1:0]   mem_be_o,
  output logic [1:0]        mem_size_o,
  output logic              mem_approx_o,
  input  logic              mem_gnt_i
);

  localparam int SPW    = $clog2(DEPTH_SPEC);
  localparam int CPW    = $clog2(DEPTH_COMMIT);
  localparam int WORD_W = ADDR_W - OFF_W;
  localparam int PAGE_W = 12 - OFF_W;

  typedef struct packed {
    logic              valid;
    logic              approx;
    logic [1:0]        size;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t         spec_q   [DEPTH_SPEC];
  entry_t         commit_q [DEPTH_COMMIT];
  logic [SPW-1:0] spec_rptr_q, spec_wptr_q;
  logic [SPW:0]   spec_cnt_q;
  logic [CPW-1:0] commit_rptr_q, commit_wptr_q;
  logic [CPW:0]   commit_cnt_q;

  logic push, commit, grant;

  assign ready_o         = spec_cnt_q < (SPW+1)'(DEPTH_SPEC);
  assign commit_ready_o  = commit_cnt_q < (CPW+1)'(DEPTH_COMMIT);
  assign no_st_pending_o = commit_cnt_q == '0;
  assign push            = valid_i && !flush_i;
  assign commit          = commit_i && !flush_i;
  assign grant           = mem_gnt_i && mem_req_o;

  assign mem_req_o    = commit_q[commit_rptr_q].valid;
  assign mem_addr_o   = commit_q[commit_rptr_q].addr;
  assign mem_wdata_o  = commit_q[commit_rptr_q].data;
  assign mem_be_o     = commit_q[commit_rptr_q].be;
  assign mem_size_o   = commit_q[commit_rptr_q].size;
  assign mem_approx_o = commit_q[commit_rptr_q].approx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH_SPEC; i++) spec_q[i] <= '0;
      for (int i = 0; i < DEPTH_COMMIT; i++) commit_q[i] <= '0;
      spec_rptr_q   <= '0;
      spec_wptr_q   <= '0;
      spec_cnt_q    <= '0;
      commit_rptr_q <= '0;
      commit_wptr_q <= '0;
      commit_cnt_q  <= '0;
    end else begin
      if (flush_i) begin
        for (int i = 0; i < DEPTH_SPEC; i++) spec_q[i].valid <= 1'b0;
        spec_wptr_q <= spec_rptr_q;
        spec_cnt_q  <= '0;
      end else begin
        if (push) begin
          spec_q[spec_wptr_q] <= '{valid: 1'b1, approx: approx_i, size: size_i,
                                   be: be_i, data: data_i, addr: paddr_i};
          spec_wptr_q <= spec_wptr_q + SPW'(1);
        end
        if (commit) begin
          commit_q[commit_wptr_q]   <= spec_q[spec_rptr_q];
          spec_q[spec_rptr_q].valid <= 1'b0;
          spec_rptr_q               <= spec_rptr_q + SPW'(1);
          commit_wptr_q             <= commit_wptr_q + CPW'(1);
        end
        spec_cnt_q <= spec_cnt_q + (SPW+1)'(push) - (SPW+1)'(commit);
      end
      if (grant) begin
        commit_q[commit_rptr_q].valid <= 1'b0;
        commit_rptr_q                 <= commit_rptr_q + CPW'(1);
      end
      commit_cnt_q <= commit_cnt_q + (CPW+1)'(commit) - (CPW+1)'(grant);
    end
  end

  logic [DEPTH_SPEC-1:0]   spec_valid;
  logic [WORD_W-1:0]       spec_word   [DEPTH_SPEC];
  logic [DEPTH_COMMIT-1:0] commit_valid;
  logic [WORD_W-1:0]       commit_word [DEPTH_COMMIT];

  always_comb begin
    for (int i = 0; i < DEPTH_SPEC; i++) begin
      spec_valid[i] = spec_q[i].valid;
      spec_word[i]  = spec_q[i].addr[ADDR_W-1:OFF_W];
    end
    for (int i = 0; i < DEPTH_COMMIT; i++) begin
      commit_valid[i] = commit_q[i].valid;
      commit_word[i]  = commit_q[i].addr[ADDR_W-1:OFF_W];
    end
  end

  logic           s_match, s_page, c_match, c_page;
  logic [SPW-1:0] s_idx;
  logic [CPW-1:0] c_idx;

  sb_fwd_select #(.DEPTH(DEPTH_SPEC), .WORD_W(WORD_W), .PAGE_W(PAGE_W)) u_spec_sel (
    .valid(spec_valid), .word(spec_word), .rptr(spec_rptr_q), .wptr(spec_wptr_q),
    .probe_word(ld_paddr_i[ADDR_W-1:OFF_W]), .match(s_match), .index(s_idx), .page_hit(s_page)
  );

  sb_fwd_select #(.DEPTH(DEPTH_COMMIT), .WORD_W(WORD_W), .PAGE_W(PAGE_W)) u_commit_sel (
    .valid(commit_valid), .word(commit_word), .rptr(commit_rptr_q), .wptr(commit_wptr_q),
    .probe_word(ld_paddr_i[ADDR_W-1:OFF_W]), .match(c_match), .index(c_idx), .page_hit(c_page)
  );

  logic   ld_off_unused;
  entry_t sel;
  logic   push_word, push_page, covered;

  assign ld_off_unused = ^ld_paddr_i[OFF_W-1:0];

  // An incoming store to the probed word is younger than anything buffered, so it vetoes the hit.
  always_comb begin
    sel           = s_match ? spec_q[s_idx] : commit_q[c_idx];
    push_word     = valid_i && paddr_i[ADDR_W-1:OFF_W] == ld_paddr_i[ADDR_W-1:OFF_W];
    push_page     = valid_i && paddr_i[11:OFF_W] == ld_paddr_i[11:OFF_W];
    covered       = (sel.be & ld_be_i) == ld_be_i;
    ld_fwd_hit_o  = ld_valid_i && (s_match || c_match) && covered && !push_word;
    ld_fwd_data_o = ld_fwd_hit_o ? sel.data : '0;
    ld_stall_o    = ld_valid_i && !ld_fwd_hit_o && (s_page || c_page || push_page);
  end

  a_push_legal : assert property (@(posedge clk_i) disable iff (rst_i) valid_i |-> ready_o);
  a_commit_legal : assert property (@(posedge clk_i) disable iff (rst_i)
    (commit_i && !flush_i) |-> (spec_cnt_q != '0 && commit_ready_o));

endmodule

// File: tb/tb_store_fwd_buffer.sv
// Scoreboard bench for store_fwd_buffer: drain order, forwarding and stall behaviour.
module tb_store_fwd_buffer;
  import ariane_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, flush_i = 1'b0, valid_i = 1'b0, commit_i = 1'b0;
  logic [63:0] paddr_i = '0, data_i = '0, ld_paddr_i = '0;
  logic [7:0]  be_i = '0, ld_be_i = '0;
  logic [1:0]  size_i = '0;
  logic        approx_i = 1'b0, ld_valid_i = 1'b0, mem_gnt_i = 1'b0;
  logic        ready_o, commit_ready_o, no_st_pending_o, ld_fwd_hit_o, ld_stall_o;
  logic        mem_req_o, mem_approx_o;
  logic [63:0] ld_fwd_data_o, mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_be_o;
  logic [1:0]  mem_size_o;

  int checks = 0, errors = 0, drained = 0;
  sb_entry_t spec_m[$];
  sb_entry_t mem_m[$];

  always #5 clk = ~clk;

  store_fwd_buffer dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .paddr_i(paddr_i),
    .data_i(data_i), .be_i(be_i), .size_i(size_i), .approx_i(approx_i), .ready_o(ready_o),
    .commit_i(commit_i), .commit_ready_o(commit_ready_o), .no_st_pending_o(no_st_pending_o),
    .ld_valid_i(ld_valid_i), .ld_paddr_i(ld_paddr_i), .ld_be_i(ld_be_i),
    .ld_fwd_hit_o(ld_fwd_hit_o), .ld_fwd_data_o(ld_fwd_data_o), .ld_stall_o(ld_stall_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .mem_size_o(mem_size_o), .mem_approx_o(mem_approx_o),
    .mem_gnt_i(mem_gnt_i)
  );

  // Checks the drain head against the model, then applies this edge's inputs to the model.
  task automatic tick();
    sb_entry_t e;
    if (!rst_i) begin
      checks++;
      if (mem_req_o !== (mem_m.size() != 0)) begin
        errors++; $display("[TB] FAIL mem_req: got %b want %b", mem_req_o, mem_m.size() != 0);
      end
      if (mem_gnt_i && mem_req_o && mem_m.size() > 0) begin
        e = mem_m.pop_front(); drained++; checks++;
        if ({mem_addr_o, mem_wdata_o, mem_be_o, mem_size_o, mem_approx_o} !==
            {e.addr, e.data, e.be, e.size, e.approx}) begin
          errors++;
          $display("[TB] FAIL drain: got a=%h d=%h be=%h sz=%0d ap=%b want a=%h d=%h be=%h sz=%0d ap=%b",
                   mem_addr_o, mem_wdata_o, mem_be_o, mem_size_o, mem_approx_o,
                   e.addr, e.data, e.be, e.size, e.approx);
        end
      end
    end
    if (rst_i) begin
      spec_m.delete(); mem_m.delete();
    end else if (flush_i) begin
      spec_m.delete();
    end else begin
      if (commit_i && spec_m.size() > 0) mem_m.push_back(spec_m.pop_front());
      if (valid_i) begin
        e = '{valid: 1'b1, approx: approx_i, size: size_i, be: be_i, data: data_i, addr: paddr_i};
        spec_m.push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    flush_i = 0; valid_i = 0; commit_i = 0; ld_valid_i = 0; mem_gnt_i = 0;
    paddr_i = '0; data_i = '0; be_i = '0; size_i = '0; approx_i = 0; ld_paddr_i = '0; ld_be_i = '0;
  endtask

  task automatic do_reset();
    set_idle(); rst_i = 1; tick(); tick(); rst_i = 0;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be,
                      input logic [1:0] sz, input logic ap);
    valid_i = 1; paddr_i = a; data_i = d; be_i = be; size_i = sz; approx_i = ap;
    tick(); valid_i = 0;
  endtask

  task automatic probe(input logic [63:0] a, input logic [7:0] be);
    ld_valid_i = 1; ld_paddr_i = a; ld_be_i = be; #1;
  endtask

  task automatic test_reset();
    do_reset();
    probe(64'h1000, 8'hFF);
    checks += 7;
    if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready: got %b want 1", ready_o); end
    if (commit_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_commit_ready: got %b want 1", commit_ready_o); end
    if (no_st_pending_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_no_st: got %b want 1", no_st_pending_o); end
    if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_req: got %b want 0", mem_req_o); end
    if (ld_fwd_hit_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_hit: got %b want 0", ld_fwd_hit_o); end
    if (ld_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall: got %b want 0", ld_stall_o); end
    if (ld_fwd_data_o !== 64'h0) begin errors++; $display("[TB] FAIL rst_data: got %h want 0", ld_fwd_data_o); end
    ld_valid_i = 0;
  endtask

  task automatic test_forward();
    do_reset();
    push(64'h1000, 64'h1122334455667788, 8'hFF, 2'd3, 1'b0);
    probe(64'h1000, 8'h0F);
    checks += 3;
    if (ld_fwd_hit_o !== 1'b1) begin errors++; $display("[TB] FAIL fwd_hit: got %b want 1", ld_fwd_hit_o); end
    if (ld_fwd_data_o !== 64'h1122334455667788) begin errors++; $display("[TB] FAIL fwd_data: got %h want 1122334455667788", ld_fwd_data_o); end
    if (ld_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL fwd_stall: got %b want 0", ld_stall_o); end
    probe(64'h5010, 8'hFF);
    checks += 2;
    if (ld_fwd_hit_o !== 1'b0) begin errors++; $display("[TB] FAIL miss_hit: got %b want 0", ld_fwd_hit_o); end
    if (ld_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL miss_stall: got %b want 0", ld_stall_o); end
    probe(64'h5000, 8'hFF);
    checks += 2;
    if (ld_fwd_hit_o !== 1'b0) begin errors++; $display("[TB] FAIL alias_hit: got %b want 0", ld_fwd_hit_o); end
    if (ld_stall_o !== 1'b1) begin errors++; $display("[TB] FAIL alias_stall: got %b want 1", ld_stall_o); end
    ld_valid_i = 0;
  endtask

  task automatic test_partial();
    do_reset();
    push(64'h1000, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 2'd3, 1'b0);
    push(64'h1000, 64'hBBBBBBBBBBBBBBBB, 8'hF0, 2'd3, 1'b1);
    probe(64'h1000, 8'hFF);
    checks += 3;
    if (ld_fwd_hit_o !== 1'b0) begin errors++; $display("[TB] FAIL part_hit: got %b want 0", ld_fwd_hit_o); end
    if (ld_stall_o !== 1'b1) begin errors++; $display("[TB] FAIL part_stall: got %b want 1", ld_stall_o); end
    if (ld_fwd_data_o !== 64'h0) begin errors++; $display("[TB] FAIL part_data: got %h want 0", ld_fwd_data_o); end
    probe(64'h1000, 8'hF0);
    checks += 2;
    if (ld_fwd_hit_o !== 1'b1) begin errors++; $display("[TB] FAIL young_hit: got %b want 1", ld_fwd_hit_o); end
    if (ld_fwd_data_o !== 64'hBBBBBBBBBBBBBBBB) begin errors++; $display("[TB] FAIL young_data: got %h want BBBBBBBBBBBBBBBB", ld_fwd_data_o); end
    probe(64'h1000, 8'h0F);
    checks += 2;
    if (ld_fwd_hit_o !== 1'b0) begin errors++; $display("[TB] FAIL old_hit: got %b want 0", ld_fwd_hit_o); end
    if (ld_stall_o !== 1'b1) begin errors++; $display("[TB] FAIL old_stall: got %b want 1", ld_stall_o); end
    ld_valid_i = 0;
  endtask

  task automatic test_flush();
    do_reset();
    push(64'h1100, 64'h0000000000001100, 8'hFF, 2'd3, 1'b0);
    push(64'h1200, 64'h0000000000001200, 8'hFF, 2'd3, 1'b1);
    push(64'h1300, 64'h0000000000001300, 8'hFF, 2'd3, 1'b0);
    commit_i = 1; tick(); commit_i = 0;
    flush_i = 1; tick(); flush_i = 0;
    checks += 2;
    if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready: got %b want 1", ready_o); end
    if (no_st_pending_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_st: got %b want 0", no_st_pending_o); end
    probe(64'h1200, 8'hFF);
    checks += 2;
    if (ld_stall_o !== 1'b0) begin errors++; $display("[TB] FAIL flushed_stall: got %b want 0", ld_stall_o); end
    if (ld_fwd_hit_o !== 1'b0) begin errors++; $display("[TB] FAIL flushed_hit: got %b want 0", ld_fwd_hit_o); end
    probe(64'h1100, 8'hFF);
    checks += 2;
    if (ld_fwd_hit_o !== 1'b1) begin errors++; $display("[TB] FAIL committed_hit: got %b want 1", ld_fwd_hit_o); end
    if (ld_fwd_data_o !== 64'h1100) begin errors++; $display("[TB] FAIL committed_data: got %h want 1100", ld_fwd_data_o); end
    ld_valid_i = 0;
    tick(); tick();
    for (int i = 0; i < 3; i++) push(64'h2000 + 64'(i * 8), 64'(i), 8'hFF, 2'd3, 1'b0);
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL cnt3_ready: got %b want 1", ready_o); end
    push(64'h2018, 64'h3, 8'hFF, 2'd3, 1'b0);
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("[TB] FAIL cnt4_ready: got %b want 0", ready_o); end
    mem_gnt_i = 1; tick(); mem_gnt_i = 0;
    checks += 2;
    if (no_st_pending_o !== 1'b1) begin errors++; $display("[TB] FAIL drained_no_st: got %b want 1", no_st_pending_o); end
    if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL drained_req: got %b want 0", mem_req_o); end
  endtask

  task automatic test_commit_full();
    int d0;
    do_reset();
    d0 = drained;
    for (int i = 0; i < 8; i++) begin
      push(64'h3000 + 64'(i * 8), {$urandom, $urandom}, 8'(1 << (i % 8)), 2'(i), 1'(i));
      commit_i = 1; tick(); commit_i = 0;
    end
    checks += 2;
    if (commit_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b want 0", commit_ready_o); end
    if (no_st_pending_o !== 1'b0) begin errors++; $display("[TB] FAIL full_no_st: got %b want 0", no_st_pending_o); end
    mem_gnt_i = 1; tick(); mem_gnt_i = 0;
    checks++;
    if (commit_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL after_gnt_ready: got %b want 1", commit_ready_o); end
    mem_gnt_i = 1;
    for (int c = 0; c < 20 && mem_m.size() > 0; c++) tick();
    mem_gnt_i = 0;
    checks += 2;
    if (drained - d0 !== 8) begin errors++; $display("[TB] FAIL full_drained: got %0d want 8", drained - d0); end
    if (no_st_pending_o !== 1'b1) begin errors++; $display("[TB] FAIL full_end_no_st: got %b want 1", no_st_pending_o); end
  endtask

  task automatic test_back_to_back();
    int d0, pushed;
    do_reset();
    d0 = drained; pushed = 0;
    for (int c = 0; c < 300 && (pushed < 12 || spec_m.size() > 0); c++) begin
      valid_i  = pushed < 12 && spec_m.size() < 4;
      commit_i = spec_m.size() > 0 && mem_m.size() < 8;
      paddr_i  = 64'h8000 + 64'(pushed * 8);
      data_i   = {$urandom, $urandom};
      be_i     = 8'($urandom);
      size_i   = 2'($urandom);
      approx_i = 1'($urandom);
      mem_gnt_i = 1'($urandom);
      if (valid_i) pushed++;
      tick();
    end
    set_idle();
    mem_gnt_i = 1;
    for (int c = 0; c < 30 && mem_m.size() > 0; c++) tick();
    mem_gnt_i = 0;
    checks += 2;
    if (drained - d0 !== 12) begin errors++; $display("[TB] FAIL wrap_drained: got %0d want 12", drained - d0); end
    if (no_st_pending_o !== 1'b1) begin errors++; $display("[TB] FAIL wrap_no_st: got %b want 1", no_st_pending_o); end
  endtask

  task automatic test_page_stall();
    do_reset();
    valid_i = 1; paddr_i = 64'h3008; data_i = 64'h77; be_i = 8'hFF; size_i = 2'd3; approx_i = 0;
    probe(64'h2008, 8'hFF);
    checks += 2;
    if (ld_stall_o !== 1'b1) begin errors++; $display("[TB] FAIL push_page_stall: got %b want 1", ld_stall_o); end
    if (ld_fwd_hit_o !== 1'b0) begin errors++; $display("[TB] FAIL push_page_hit: got %b want 0", ld_fwd_hit_o); end
    tick(); valid_i = 0; #1;
    checks++;
    if (ld_stall_o !== 1'b1) begin errors++; $display("[TB] FAIL buf_page_stall: got %b want 1", ld_stall_o); end
    ld_valid_i = 0;
    push(64'h4000, 64'hCAFEF00DDEADBEEF, 8'hFF, 2'd3, 1'b0);
    valid_i = 1; paddr_i = 64'h4000; data_i = 64'h1;
    probe(64'h4000, 8'hFF);
    checks += 2;
    if (ld_fwd_hit_o !== 1'b0) begin errors++; $display("[TB] FAIL veto_hit: got %b want 0", ld_fwd_hit_o); end
    if (ld_stall_o !== 1'b1) begin errors++; $display("[TB] FAIL veto_stall: got %b want 1", ld_stall_o); end
    valid_i = 0; #1;
    checks++;
    if (ld_fwd_data_o !== 64'hCAFEF00DDEADBEEF) begin errors++; $display("[TB] FAIL noveto_data: got %h want CAFEF00DDEADBEEF", ld_fwd_data_o); end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_forward();
    test_partial();
    test_flush();
    test_commit_full();
    test_back_to_back();
    test_page_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
